// File: rtl/motor_soft_ramp.sv
// Soft-start/soft-stop ramp from the requested PWM level to the applied level, plus PWM output.
// Define MOTOR_BRAKE_EN to add the i_brake port and the BRAKE state.
module motor_soft_ramp #(
  parameter int PWM_PERIOD   = 100,
  parameter int DWELL_CYCLES = 1000,
  parameter int LEVEL_MAX    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_pwm_state,
`ifdef MOTOR_BRAKE_EN
  input  logic       i_brake,
`endif
  output logic [2:0] o_level,
  output logic       o_busy,
  output logic       o_pwm
);

  localparam int STEP = PWM_PERIOD / LEVEL_MAX;
  localparam int CW   = $clog2(PWM_PERIOD + 1);
  localparam int DW   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [2:0]    LVL_MAX    = 3'(LEVEL_MAX);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

`ifdef MOTOR_BRAKE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2, S_BRAKE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2} state_t;
`endif

  state_t        r_state, w_next_state;
  logic [2:0]    r_level, w_next_level;
  logic [DW-1:0] r_dwell, w_next_dwell;
  logic          r_busy;
  logic          r_pwm;
  logic [CW-1:0] r_pwm_cnt;
  logic [2:0]    r_duty;
  logic [2:0]    w_tgt;
  logic [CW-1:0] w_thresh;
  logic          w_dwell_done;

  assign w_tgt        = (i_pwm_state > LVL_MAX) ? LVL_MAX : i_pwm_state;
  assign w_dwell_done = (r_dwell == DWELL_LAST);
  assign w_thresh     = CW'(r_duty) * CW'(STEP);

  // Ramp next-state: reversal or stop pre-empts a pending step on the same edge
  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    w_next_dwell = r_dwell;
`ifdef MOTOR_BRAKE_EN
    if (i_brake) begin
      w_next_state = S_BRAKE;
      w_next_level = 3'd0;
      w_next_dwell = DWELL_ZERO;
    end else
`endif
    begin
      case (r_state)
        S_IDLE: begin
          if (w_tgt > r_level) begin
            w_next_state = S_UP;
            w_next_dwell = DWELL_ZERO;
          end else if (w_tgt < r_level) begin
            w_next_state = S_DOWN;
            w_next_dwell = DWELL_ZERO;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_UP: begin
          if (w_tgt < r_level) begin
            w_next_state = S_DOWN;
            w_next_dwell = DWELL_ZERO;
          end else if (w_tgt == r_level) begin
            w_next_state = S_IDLE;
            w_next_dwell = DWELL_ZERO;
          end else if (w_dwell_done) begin
            w_next_level = r_level + 3'd1;
            w_next_dwell = DWELL_ZERO;
            w_next_state = ((r_level + 3'd1) == w_tgt) ? S_IDLE : S_UP;
          end else begin
            w_next_dwell = r_dwell + DW'(1);
          end
        end
        S_DOWN: begin
          if (w_tgt > r_level) begin
            w_next_state = S_UP;
            w_next_dwell = DWELL_ZERO;
          end else if (w_tgt == r_level) begin
            w_next_state = S_IDLE;
            w_next_dwell = DWELL_ZERO;
          end else if (w_dwell_done) begin
            w_next_level = r_level - 3'd1;
            w_next_dwell = DWELL_ZERO;
            w_next_state = ((r_level - 3'd1) == w_tgt) ? S_IDLE : S_DOWN;
          end else begin
            w_next_dwell = r_dwell + DW'(1);
          end
        end
`ifdef MOTOR_BRAKE_EN
        S_BRAKE: begin
          w_next_state = S_IDLE;
        end
`endif
        default: begin
          w_next_state = S_IDLE;
          w_next_level = 3'd0;
          w_next_dwell = DWELL_ZERO;
        end
      endcase
    end
  end

  // Ramp state, level, dwell counter and busy flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_level <= 3'd0;
      r_dwell <= DWELL_ZERO;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_level <= w_next_level;
      r_dwell <= w_next_dwell;
      r_busy  <= (w_next_state == S_UP) || (w_next_state == S_DOWN);
    end
  end

  // Free-running PWM; duty is latched only at the period wrap so edges stay glitch-free
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pwm_cnt <= CNT_ZERO;
      r_duty    <= 3'd0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == CNT_LAST) ? CNT_ZERO : r_pwm_cnt + CW'(1);
`ifdef MOTOR_BRAKE_EN
      if (i_brake) begin
        r_duty <= 3'd0;
        r_pwm  <= 1'b0;
      end else
`endif
      begin
        if (r_pwm_cnt == CNT_LAST) begin
          r_duty <= r_level;
        end else begin
          r_duty <= r_duty;
        end
        r_pwm <= (r_pwm_cnt < w_thresh);
      end
    end
  end

  assign o_level = r_level;
  assign o_busy  = r_busy;
  assign o_pwm   = r_pwm;

endmodule
